// File: rtl/sha256_msg_ctrl.sv
// rtl/sha256_msg_ctrl.sv - SHA-256 message padder and block sequencer in front of sha256_engine
// Optional SHA256_MSG_CTRL_BSWAP_EN: input words arrive little-endian and are byte-swapped on entry.

module sha256_msg_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [31:0]  len_i,
    output logic         busy_o,
    input  logic         s_vld_i,
    input  logic [31:0]  s_dat_i,
    output logic         s_rdy_o,
    output logic         fifo_wr_en_o,
    output logic [31:0]  fifo_wr_dat_o,
    input  logic         fifo_full_i,
    output logic         eng_rst_o,
    output logic         eng_start_o,
    input  logic         eng_ready_i,
    input  logic         eng_valid_i,
    input  logic [255:0] eng_hash_i,
    output logic [255:0] hash_o,
    output logic         hash_vld_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERST,
        S_FILL,
        S_KICK,
        S_WAIT,
        S_FIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    len_q, len_d;
    logic [30:0]    n_words_q, n_words_d;
    logic [30:0]    m_q, m_d;
    logic [3:0]     j_q, j_d;
    logic [26:0]    blk_left_q, blk_left_d;
    logic           erst_cnt_q, erst_cnt_d;
    logic           wr_en_d;
    logic [31:0]    wr_dat_d;
    logic           eng_start_d;
    logic [255:0]   hash_d;
    logic           hash_vld_d;

    logic [31:0]    in_word;
    logic [31:0]    pad_word;
    logic           has_data;
    logic           last_word;
    logic           last_blk;
    logic           accept;

    always_comb begin
`ifdef SHA256_MSG_CTRL_BSWAP_EN
        in_word = {s_dat_i[7:0], s_dat_i[15:8], s_dat_i[23:16], s_dat_i[31:24]};
`else
        in_word = s_dat_i;
`endif
    end

    assign has_data  = (m_q < n_words_q);
    assign last_word = ((m_q + 31'd1) == n_words_q);
    assign last_blk  = (blk_left_q == 27'd0);

    // Length words win in the last block; block count guarantees data and marker end before j=14.
    always_comb begin
        pad_word = 32'h0;
        if (last_blk && (j_q == 4'd14)) begin
            pad_word = {29'b0, len_q[31:29]};
        end else if (last_blk && (j_q == 4'd15)) begin
            pad_word = {len_q[28:0], 3'b0};
        end else if (has_data) begin
            pad_word = in_word;
            if (last_word) begin
                case (len_q[1:0])
                    2'd1:    pad_word = {in_word[31:24], 8'h80, 16'h0};
                    2'd2:    pad_word = {in_word[31:16], 8'h80, 8'h0};
                    2'd3:    pad_word = {in_word[31:8], 8'h80};
                    default: pad_word = in_word;
                endcase
            end
        end else if ((m_q == n_words_q) && (len_q[1:0] == 2'd0)) begin
            pad_word = 32'h8000_0000;
        end
    end

    assign accept    = (state_q == S_FILL) && !fifo_full_i && (!has_data || s_vld_i);
    assign s_rdy_o   = (state_q == S_FILL) && has_data && !fifo_full_i;
    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign eng_rst_o = (state_q == S_IDLE) || (state_q == S_ERST);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        n_words_d   = n_words_q;
        m_d         = m_q;
        j_d         = j_q;
        blk_left_d  = blk_left_q;
        erst_cnt_d  = erst_cnt_q;
        wr_en_d     = 1'b0;
        wr_dat_d    = fifo_wr_dat_o;
        eng_start_d = 1'b0;
        hash_d      = hash_o;
        hash_vld_d  = hash_vld_o;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d      = len_i;
                    n_words_d  = {1'b0, len_i[31:2]} + {30'b0, |len_i[1:0]};
                    blk_left_d = {1'b0, len_i[31:6]} + {26'b0, (len_i[5:0] >= 6'd56)};
                    m_d        = 31'd0;
                    j_d        = 4'd0;
                    erst_cnt_d = 1'b0;
                    hash_vld_d = 1'b0;
                    state_d    = S_ERST;
                end
            end
            S_ERST: begin
                erst_cnt_d = 1'b1;
                if (erst_cnt_q) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    wr_en_d  = 1'b1;
                    wr_dat_d = pad_word;
                    m_d      = m_q + 31'd1;
                    j_d      = j_q + 4'd1;
                    if (j_q == 4'd15) begin
                        state_d = S_KICK;
                    end
                end
            end
            S_KICK: begin
                eng_start_d = 1'b1;
                if (eng_start_o && !eng_ready_i) begin
                    eng_start_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_ready_i) begin
                    if (!last_blk) begin
                        blk_left_d = blk_left_q - 27'd1;
                        j_d        = 4'd0;
                        state_d    = S_FILL;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (eng_valid_i) begin
                    hash_d     = eng_hash_i;
                    hash_vld_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= 32'h0;
            n_words_q     <= 31'h0;
            m_q           <= 31'h0;
            j_q           <= 4'h0;
            blk_left_q    <= 27'h0;
            erst_cnt_q    <= 1'b0;
            fifo_wr_en_o  <= 1'b0;
            fifo_wr_dat_o <= 32'h0;
            eng_start_o   <= 1'b0;
            hash_o        <= 256'h0;
            hash_vld_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            n_words_q     <= n_words_d;
            m_q           <= m_d;
            j_q           <= j_d;
            blk_left_q    <= blk_left_d;
            erst_cnt_q    <= erst_cnt_d;
            fifo_wr_en_o  <= wr_en_d;
            fifo_wr_dat_o <= wr_dat_d;
            eng_start_o   <= eng_start_d;
            hash_o        <= hash_d;
            hash_vld_o    <= hash_vld_d;
        end
    end

endmodule

// File: doc/sha256_msg_ctrl.md
# sha256_msg_ctrl

Message sequencer in front of `sha256_engine`. It accepts a byte-length-tagged message as a stream of 32-bit words and applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit length). It writes 16-word blocks into the engine input FIFO and drives engine reset and start per block. When the final block completes it captures the 256-bit digest.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin new message; sampled only in IDLE.
- `len_i`  in  32  message length in bytes; latched with `start_i`.
- `busy_o`  out  1  high from accepted `start_i` until DONE.
- `s_vld_i`  in  1  input word valid.
- `s_dat_i`  in  32  input word, big-endian (byte 0 in [31:24]).
- `s_rdy_o`  out  1  input word accepted when `s_vld_i & s_rdy_o`.
- `fifo_wr_en_o`  out  1  write strobe to engine FIFO.
- `fifo_wr_dat_o`  out  32  word written.
- `fifo_full_i`  in  1  engine FIFO full.
- `eng_rst_o`  out  1  active-high reset to engine; the top level inverts it to the engine's `rstn`.
- `eng_start_o`  out  1  engine `start_i`.
- `eng_ready_i`  in  1  engine `ready_o`.
- `eng_valid_i`  in  1  engine `valid_o`.
- `eng_hash_i`  in  256  engine `hash_o`.
- `hash_o`  out  256  captured digest.
- `hash_vld_o`  out  1  digest valid (level).

## Operation
- Words expected: N = ceil(len/4). Valid bytes in last word: len[1:0], where 0 means 4.
- Total blocks: B = floor((len+8)/64)+1. Each block is 16 words.
- States:
  - IDLE: wait for `start_i`. On start, latch len, clear `hash_vld_o`, go to ERST.
  - ERST: `eng_rst_o`=1 for exactly 2 cycles, then go to FILL.
  - FILL: emit one word per cycle when `!fifo_full_i`. The word source is selected by message word index m and block word index j:
    - m<N: input data. `s_rdy_o`=`!fifo_full_i`. A partial last word is masked, with 0x80 placed in the first invalid byte.
    - m==N with len[1:0]==0: 0x80000000.
    - Otherwise zero.
    - In the last block, j=14 carries {29'b0, len[31:29]} and j=15 carries {len[28:0], 3'b0}.
    - After j=15 is written, go to KICK.
  - KICK: assert `eng_start_o` until `eng_ready_i` falls, then go to WAIT.
  - WAIT: wait for `eng_ready_i`=1. If blocks remain, go to FILL with j=0. Otherwise go to FIN.
  - FIN: wait for `eng_valid_i`. Register `eng_hash_i` into `hash_o`, set `hash_vld_o`, go to DONE.
  - DONE: drop `busy_o`, go to IDLE.
- The next block is never written before the engine returns ready. This keeps the FIFO empty at the end of the final block so the engine raises valid.
- len=0: one block, 0x80000000 followed by zeros and a zero length. No input words are consumed.
- 0x80 falling at j=14 or j=15 (len mod 64 in 56..63) forces an extra all-padding block.
- `start_i` outside IDLE is ignored.
- `s_rdy_o`=0 outside FILL, and also once m≥N.

## Timing
- Reset values: `busy_o`=0, `s_rdy_o`=0, `fifo_wr_en_o`=0, `fifo_wr_dat_o`=0, `eng_rst_o`=1, `eng_start_o`=0, `hash_o`=0, `hash_vld_o`=0, state IDLE.
- `eng_rst_o` is held high through IDLE so the engine is always freshly initialised. It deasserts at the start of FILL.
- `start_i` to first FIFO write: 3 cycles minimum.
- FIFO writes are registered. `fifo_wr_en_o` asserts the cycle after the accept decision and is never asserted in the cycle after `fifo_full_i` was seen high.
- `eng_start_o` rises the cycle after the j=15 write.
- Capture: `hash_vld_o` rises 1 cycle after `eng_valid_i` is seen in FIN.
- Synchronous `rst` mid-message returns all state and outputs to reset values on the next edge. Pending input words are not consumed.

## Configuration
- `SHA256_MSG_CTRL_BSWAP_EN`:
  - Defined: `s_dat_i` is byte-swapped on entry (little-endian CPU word, byte 0 in [7:0]) before masking and padding.
  - Undefined: words are used as-is (big-endian).
  - The length words and 0x80 insertion are unaffected by the macro.

## Test plan
- len=0, no input words -> `hash_o` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with exactly 16 FIFO writes.
- len=3, word 0x61626300 ("abc") -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; FIFO word 0 = 0x61626380, word 15 = 0x00000018.
- len=56, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; 32 FIFO writes, two KICKs.
- "abc" with `fifo_full_i` toggled every other cycle and `s_vld_i` gapped -> same digest, no write while full, no input word lost or duplicated.
- `rst` pulsed during the second block of the len=56 case, then len=3 run -> all outputs at reset values after the edge, then the "abc" digest is correct.
- `SHA256_MSG_CTRL_BSWAP_EN` defined, len=3, word 0x00636261 -> "abc" digest.
